// File: rtl/ascon_perm_seq_if.sv
// Request/response handshake bundle for the Ascon-p permutation engine.
// The master is the requester (drives the state in, takes the result),
// the slave is the engine.
interface ascon_perm_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   rounds;
  logic [319:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [319:0] state_out;

  modport master (
    output in_valid, rounds, state_in, out_ready,
    input  in_ready, out_valid, state_out
  );

  modport slave (
    input  in_valid, rounds, state_in, out_ready,
    output in_ready, out_valid, state_out
  );
endinterface

// File: rtl/ascon_perm_seq.sv
// Iterative Ascon-p permutation: one round per clock, 0..12 rounds per job.
// Word packing is {x0,x1,x2,x3,x4} with x0 in the top 64 bits. A job with
// nr rounds runs rounds r = 12-nr .. 11, so shortened permutations use the
// tail of the round-constant schedule. A zero-round job still spends one
// pass-through cycle in RUN, giving the one-cycle minimum latency.
module ascon_perm_seq (
  input  logic              g_clk,
  input  logic              g_rst,
  ascon_perm_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  // Per-word diffusion: x ^ ror(x,a) ^ ror(x,b), same as the sigma ISE stage.
  function automatic logic [63:0] sigma(input logic [63:0] x,
                                        input int unsigned a,
                                        input int unsigned b);
    return x ^ ((x >> a) | (x << (64 - a))) ^ ((x >> b) | (x << (64 - b)));
  endfunction

  // One full Ascon round: constant addition, bitsliced S-box, linear layer.
  function automatic logic [319:0] ascon_round(input logic [319:0] s,
                                               input logic [3:0]   r);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    // NOTE: function locals are combinational temporaries, so blocking '='
    // is correct here; each line sees the value produced by the line above.
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128];
    x3 = s[127:64];
    x4 = s[63:0];

    x2 = x2 ^ {56'b0, 4'hF - r, r};

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    x0 = sigma(x0, 19, 28);
    x1 = sigma(x1, 61, 39);
    x2 = sigma(x2, 1, 6);
    x3 = sigma(x3, 10, 17);
    x4 = sigma(x4, 7, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [319:0] st_q, st_d;
  logic [3:0]   nr_q, nr_d;
  logic [3:0]   i_q, i_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;

  logic [3:0]   rnd;
  logic [319:0] round_out;
  logic         last_round;

  // Round datapath: current round index and the state after one round.
  always_comb begin
    rnd        = 4'd12 - nr_q + i_q;
    round_out  = ascon_round(st_q, rnd);
    last_round = (nr_q == 4'd0) || (i_q == nr_q - 4'd1);
  end

  // Next-state logic for the IDLE -> RUN -> DONE sequencer and its outputs.
  always_comb begin
    // NOTE: every _d signal takes its hold value first so that no path
    // through the case statement leaves it unassigned (no latches).
    fsm_d       = fsm_q;
    st_d        = st_q;
    nr_d        = nr_q;
    i_d         = i_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    unique case (fsm_q)
      IDLE: begin
        if (bus.in_valid) begin
          st_d       = bus.state_in;
          nr_d       = (bus.rounds > 4'd12) ? 4'd12 : bus.rounds;
          i_d        = 4'd0;
          in_ready_d = 1'b0;
          fsm_d      = RUN;
        end
      end
      RUN: begin
        if (nr_q != 4'd0) begin
          st_d = round_out;
          i_d  = i_q + 4'd1;
        end
        if (last_round) begin
          out_valid_d = 1'b1;
          fsm_d       = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          fsm_d       = IDLE;
        end
      end
      default: begin
        fsm_d       = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered handshake outputs, synchronous active-high reset.
  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      fsm_q       <= IDLE;
      // NOTE: the wide state register is reset on purpose: state_out is
      // visible in every state and must read zero after reset.
      st_q        <= '0;
      nr_q        <= 4'd0;
      i_q         <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      st_q        <= st_d;
      nr_q        <= nr_d;
      i_q         <= i_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.state_out = st_q;

endmodule
